// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_pkg
// Purpose : Shared definitions for the MAC job sequencer: default widths,
//           FSM state encoding and default-width accumulator limits.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int LEN_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Saturation limits for the default accumulator width.
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/mac_acc_core.sv
`default_nettype none
// ============================================================================
// Module  : mac_acc_core
// Purpose : Registered signed multiply followed by an accumulate stage with
//           sticky overflow detection. Build macro MAC_SAT_EN selects
//           saturating accumulation; otherwise the sum wraps.
// Ports   : clk, rst (sync, active-low), clr (clear job state),
//           en (operand pair accepted), a/b (signed operands),
//           acc (accumulator), ovf (sticky overflow)
// Revision: 1.0 - initial release
// ============================================================================
module mac_acc_core
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);

  localparam int PW = 2 * DATA_W;
  localparam logic [ACC_W-1:0] LIM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LIM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PW-1:0]    prod_full;
  logic signed [ACC_W-1:0] p_q;
  logic                    p_vld;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf_now;
  logic signed [ACC_W-1:0] acc_next;

  // Operands widened first so the product is computed at full precision.
  assign prod_full = PW'(a) * PW'(b);
  assign sum       = acc + p_q;
  // Signed overflow: addends agree in sign but the sum does not.
  assign ovf_now   = p_vld && (acc[ACC_W-1] == p_q[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_SAT_EN
  // Overflow direction follows the sign of the addend.
  assign acc_next = ovf_now ? (p_q[ACC_W-1] ? LIM_MIN : LIM_MAX) : sum;
`else
  assign acc_next = sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q   <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      p_q   <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (en) begin
        p_q   <= ACC_W'(prod_full);
        p_vld <= 1'b1;
      end else begin
        p_vld <= 1'b0;
      end
      if (p_vld) acc <= acc_next;
      if (ovf_now) ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mac_seq_ctrl
// Purpose : Job sequencer for the signed MAC datapath. Accepts a length,
//           streams that many operand pairs through mac_acc_core and returns
//           the dot product on a valid/ready output.
//           Build macro MAC_SAT_EN enables saturating accumulation.
// Ports   : clk, rst (sync, active-low)
//           start/cfg_len/busy            - job request
//           in_valid/in_ready/in_a/in_b   - operand stream
//           out_valid/out_ready/out_data/out_ovf - result
// Revision: 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             start_acc;
  logic             accept;

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_RUN);
  assign out_valid = (state == ST_OUT);
  assign start_acc = start && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= cfg_len;
            state     <= (cfg_len == '0) ? ST_OUT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        // The last product lands in the accumulator on this edge.
        ST_DRAIN: state <= ST_OUT;
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mac_acc_core #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (accept),
    .a   (in_a),
    .b   (in_b),
    .acc (out_data),
    .ovf (out_ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_seq_ctrl
// Purpose : Self-checking bench for mac_seq_ctrl. Table of job vectors with
//           hand-computed dot products, plus directed sequences for ignored
//           starts and mid-job reset. Expectations follow MAC_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         cfg_len = '0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_a = '0;
  logic signed [15:0] in_b = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_data;
  logic               out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mac_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [31:0]      exp_data;
    logic             exp_ovf;
    logic [1:0]       gap;
    logic [1:0]       bp;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input int len,
                              input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input logic [31:0] exp_d, input logic exp_o,
                              input int gap, input int bp);
    vec_t v;
    v.len = 8'(len);
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.a[3] = 16'(a3); v.b[3] = 16'(b3);
    v.exp_data = exp_d;
    v.exp_ovf  = exp_o;
    v.gap = 2'(gap);
    v.bp  = 2'(bp);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t;
    out_ready = (v.bp == 0);
    t = 0;
    while (busy && t < 50) begin tick(); t++; end
    chk({tag, " idle before start"}, 32'(busy), 32'd0);
    start = 1'b1; cfg_len = v.len;
    tick();
    start = 1'b0; cfg_len = 8'hA5;
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1; in_a = v.a[i]; in_b = v.b[i];
      t = 0;
      while (!in_ready && t < 50) begin tick(); t++; end
      chk({tag, " in_ready wait"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_a = 16'h5A5A; in_b = 16'hA5A5;
      if (i != int'(v.len) - 1) repeat (int'(v.gap)) tick();
    end
    if (v.len != 0) begin
      chk({tag, " no result in drain"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({tag, " out_valid latency"}, 32'(out_valid), 32'd1);
    chk({tag, " out_data"}, out_data, v.exp_data);
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    for (int k = 0; k < int'(v.bp); k++) begin
      tick();
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held out_data"}, out_data, v.exp_data);
      chk({tag, " held busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, " busy after handshake"}, 32'(busy), 32'd0);
    chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
`ifdef MAC_SAT_EN
    logic [31:0] exp_ovf3 = 32'h7FFF_FFFF;
    logic [31:0] exp_ovf4 = 32'h7FFF_FFFF;
`else
    logic [31:0] exp_ovf3 = 32'(-1073938429);
    logic [31:0] exp_ovf4 = 32'h8000_0000;
`endif
    tbl[0] = mk(4, 2, 3, 4, -1, 100, 5, -10, 2, 32'd482, 1'b0, 0, 0);
    tbl[1] = mk(4, 2, 3, 4, -1, 100, 5, -10, 2, 32'd482, 1'b0, 2, 3);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 0, 0);
    tbl[3] = mk(3, 32767, 32767, 32767, 32767, 32767, 32767, 0, 0, exp_ovf3, 1'b1, 0, 0);
    tbl[4] = mk(2, -32768, -32768, -32768, -32768, 0, 0, 0, 0, exp_ovf4, 1'b1, 1, 1);
    tbl[5] = mk(2, -32768, 32767, -32768, 32767, 0, 0, 0, 0, 32'(-2147418112), 1'b0, 0, 0);
    tbl[6] = mk(1, -7, 6, 0, 0, 0, 0, 0, 0, 32'(-42), 1'b0, 0, 0);

    // Reset state
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_ovf", 32'(out_ovf), 32'd0);
    chk("reset out_data", out_data, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Start pulsed during RUN is ignored; start during handshake is ignored.
    out_ready = 1'b1;
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b1; cfg_len = 8'd0;
    in_valid = 1'b1; in_a = 16'sd3; in_b = 16'sd4;
    tick();
    start = 1'b0;
    chk("run start ignored busy", 32'(busy), 32'd1);
    chk("run start ignored in_ready", 32'(in_ready), 32'd1);
    in_a = 16'sd5; in_b = 16'sd6;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ignored start out_valid", 32'(out_valid), 32'd1);
    chk("ignored start out_data", out_data, 32'd42);
    start = 1'b1; cfg_len = 8'd0;
    tick();
    chk("handshake start ignored busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("start after handshake busy", 32'(busy), 32'd1);
    chk("start after handshake out_valid", 32'(out_valid), 32'd1);
    chk("start after handshake out_data", out_data, 32'd0);
    tick();
    chk("zero job done", 32'(busy), 32'd0);

    // Mid-job reset after 2 of 4 pairs
    start = 1'b1; cfg_len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'sd10; in_b = 16'sd10;
    tick();
    in_a = 16'sd20; in_b = 16'sd20;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre-reset partial acc", out_data, 32'd500);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd0);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_ovf", 32'(out_ovf), 32'd0);
    chk("midreset out_data", out_data, 32'd0);
    run_vec(tbl[6], "after reset");

    // Reset while an overflowed result is waiting
    out_ready = 1'b0;
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = -16'sd32768; in_b = -16'sd32768;
    tick(); tick();
    in_valid = 1'b0;
    tick();
    chk("ovf held out_valid", 32'(out_valid), 32'd1);
    chk("ovf held out_ovf", 32'(out_ovf), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("out reset out_ovf", 32'(out_ovf), 32'd0);
    chk("out reset out_valid", 32'(out_valid), 32'd0);
    chk("out reset out_data", out_data, 32'd0);
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Job sequencer for the signed multiply-accumulate datapath.
- Accepts a job descriptor (vector length), streams that many operand pairs through a registered multiply and accumulate stage, then presents the dot-product result on a valid/ready output.
- Sits between an operand source (buffer or DMA) and a result consumer. Replaces free-running MAC accumulation with a bounded, clear-per-job accumulation.

Parameters:
- DATA_W, 16, operand width (signed)
- ACC_W, 32, accumulator/result width (signed); must be >= 2*DATA_W
- LEN_W, 8, width of the job length field (max 2^LEN_W-1 elements)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous active-low reset; 0 = reset
- start  in  1  job request; accepted only when busy=0
- cfg_len  in  LEN_W  element count, sampled on accepted start
- busy  out  1  high from accepted start until result handshake completes
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts operand pair
- in_a  in  DATA_W  signed operand A
- in_b  in  DATA_W  signed operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed dot-product result
- out_ovf  out  1  accumulator overflowed during this job (sticky per job)

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; busy, in_ready, out_valid and out_ovf = 0; out_data, accumulator, product register and counter = 0.
  - Reset mid-job discards all partial state.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start=1 latches remaining=cfg_len, clears accumulator, product-valid and ovf, and sets busy=1 at the next edge.
  - cfg_len != 0 -> RUN.
  - cfg_len == 0 -> OUT with out_data=0 and out_ovf=0.
- RUN:
  - in_ready=1 combinationally (state-decoded only; no dependence on in_valid).
  - An accepted pair (in_valid & in_ready) registers the full-precision product p = in_a*in_b (2*DATA_W, sign-extended to ACC_W), sets p_vld and decrements remaining.
  - Every cycle with p_vld=1, acc <= acc + p.
  - When the final pair is accepted (remaining==1), go to DRAIN.
  - in_valid gaps stall the count; nothing is lost or duplicated.
- DRAIN:
  - in_ready=0.
  - The final product is added to acc; at the next edge, go to OUT.
- OUT:
  - out_valid=1; out_data=acc and out_ovf are held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; busy and out_valid drop at that edge.
- Latency: result valid exactly 2 edges after the last operand acceptance, independent of length.
- Start while busy=1 is ignored and not queued. A start in the same cycle as the output handshake is ignored; the new job is accepted the next cycle in IDLE.
- in_a/in_b are ignored whenever in_ready=0.
- Overflow:
  - Detected when the signs of acc and p match and the sign of the sum differs.
  - Default: the sum wraps modulo 2^ACC_W and out_ovf is set and held until the next accepted start.
  - The product itself never overflows (-2^15 * -2^15 = 2^30 fits).

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on overflow the accumulator clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the operand sign, and stays clamped unless later products move it back in range. out_ovf is still set.
- Undefined: two's-complement wrap as above.

Decomposition:
- Shared package mac_pkg:
  - DATA_W/ACC_W/LEN_W defaults
  - state encoding constants (IDLE=0, RUN=1, DRAIN=2, OUT=3)
  - ACC_MAX/ACC_MIN constants
- Sub-module mac_acc_core:
  - product register, p_vld, accumulator with clr/en, overflow detect, and the MAC_SAT_EN saturation logic.
  - The controller instantiates it and owns the FSM, counter and handshakes.

Test Plan:
- Gapless vectors: len=4, pairs (2,3),(4,-1),(100,5),(-10,2), in_valid held 1, out_ready=1 -> out_data=482, out_ovf=0, out_valid 2 cycles after 4th acceptance.
- Bubbles and backpressure: same vectors with in_valid low 2 cycles between pairs; out_ready low 3 cycles -> out_data=482 held stable, busy=1 until handshake.
- Zero length and ignored start: start with len=0 -> out_data=0 one cycle later; start pulsed during RUN -> ignored, in-flight result unchanged.
- Overflow wrap (MAC_SAT_EN undefined): len=3, pairs (32767,32767)x3 -> out_data = 3*1073676289 mod 2^32 as signed = -1073938429, out_ovf=1.
- Saturation (MAC_SAT_EN defined): the same overflow case -> out_data=2147483647, out_ovf=1.
- Mid-job reset: rst=0 for 1 cycle after 2 of 4 pairs -> all outputs 0, state IDLE. A new len=1 job with (-7,6) -> out_data=-42, out_ovf=0.
